vga_text_console: RTL and testbench
===================================

# vga_text_console

Parametrised character terminal for the VGA path. It accepts a byte stream over a valid/ready port and interprets CR, LF, BS and FF. It keeps a COLS×ROWS character buffer with hardware scrolling and renders pixels with a blinking underline cursor and programmable colours. It sits between `vga_controller`, which supplies timing and coordinates, and the external `font_rom`, which it drives with a char code and row.

## Interface
- COLS, 80: characters per line.
- ROWS, 60: lines per screen.
- CELL, 8: glyph width and height in pixels; must be a power of 2.
- BLINK_FRAMES, 30: frames per cursor blink half-period.
- clk  in  1  pixel clock (25 MHz).
- reset_n  in  1  asynchronous, active-low reset. One clock domain, clk; reset is asynchronous and active-low.
- wr_data  in  8  character or control byte.
- wr_valid  in  1  wr_data is valid.
- wr_ready  out  1  block accepts a byte this cycle.
- busy  out  1  a clear sequence is in progress.
- fg_color, bg_color  in  12  {R,G,B} 4 bits each.
- cursor_en  in  1  enables cursor rendering.
- video_on_in, hsync_in, vsync_in  in  1  from `vga_controller`.
- x_in, y_in  in  10  pixel coordinates from `vga_controller`.
- font_code  out  8  char code to `font_rom`.
- font_row  out  log2(CELL)  glyph row to `font_rom`.
- font_bitmap  in  CELL  combinational ROM output; MSB is the leftmost pixel.
- hsync, vsync  out  1  sync outputs, delayed to match the pixel pipeline.
- red, green, blue  out  4  pixel colour.
- cursor_col  out  log2(COLS)  cursor column.
- cursor_row  out  log2(ROWS)  cursor row (logical).

## Operation
**Buffer**
- Dual-port character buffer, COLS*ROWS bytes: one write port (FSM) and one synchronous read port (display).
- Physical row = (logical row + top) mod ROWS, where `top` is the scroll offset register.
- Address = phys_row*COLS + col, width clog2(COLS*ROWS).

**Write FSM states: IDLE, CLR_LINE, CLR_ALL**
- wr_ready = 1 only in IDLE; a byte is accepted on wr_valid & wr_ready.

**Byte handling in IDLE**
- Printable byte, 0x20–0x7E:
  - Write the byte at the cursor, then col+1.
  - At col = COLS-1: col ← 0 and advance the line.
- LF, 0x0A: col ← 0, advance the line.
- CR, 0x0D: col ← 0 only, so CR+LF yields a single new line.
- BS, 0x08:
  - col > 0: col-1, write 0x20 at the new position.
  - col = 0: no-op; no reverse wrap.
- FF, 0x0C: enter CLR_ALL.
- Any other byte: accepted and discarded.

**Line advance**
- row < ROWS-1: row+1.
- row = ROWS-1: row stays, top ← (top+1) mod ROWS, enter CLR_LINE.

**Clear states**
- CLR_LINE: writes 0x20 to the physical row now shown as the last logical row, one column per cycle for COLS cycles, then returns to IDLE.
- CLR_ALL: writes 0x20 to all COLS*ROWS cells, one per cycle. On exit: top ← 0, cursor ← (0,0), IDLE.
- busy = 1 in both CLR states.

**Cursor blink**
- A frame counter counts vsync_in 1→0 edges.
- The blink phase toggles every BLINK_FRAMES frames.

## Timing
**Reset (asserted asynchronously)**
- red/green/blue = 0; hsync = vsync = 1; font_code = 0.
- Cursor = (0,0), top = 0, blink phase on.
- FSM goes to CLR_ALL: wr_ready = 0 and busy = 1 for exactly COLS*ROWS cycles after reset_n deasserts, then wr_ready = 1.
- Reset during any state aborts that state and restarts CLR_ALL.

**Accepted bytes**
- wr_ready drops the cycle after an accept only when the accept starts CLR_LINE or CLR_ALL.
- Printable, CR, LF without scroll, and BS take 1 cycle each; back-to-back accepts are allowed.

**Pixel pipeline: latency 2 cycles from x_in/y_in to RGB**
- Stage 1 registers:
  - char ← buffer[addr(x_in/CELL, y_in/CELL)];
  - font_row ← y_in mod CELL;
  - colbit ← x_in mod CELL;
  - video_on_in, and the cursor-cell hit.
- font_code = stage-1 char, combinationally.
- Stage 2 pixel select: pix = font_bitmap[CELL-1-colbit], OR'd with (cursor_en & blink & hit & font_row = CELL-1).
- Stage 2 output: RGB ← video_on_s1 ? (pix ? fg : bg) : 0.
- hsync and vsync are delayed 2 cycles.
- Pixels with x_in ≥ COLS*CELL or y_in ≥ ROWS*CELL while video_on_in = 1 render bg_color.

**Simultaneous events**
- Display reads continue during CLR states.
- A read of a cell written in the same cycle returns the old data.

## Test plan
- **Reset clear:** release reset_n → wr_ready low for exactly 4800 cycles (80×60), then high; every cell reads 0x20; RGB = bg inside the grid.
- **Write and render:** write "A" (0x41) → cursor (1,0); with fg = 0xFFF, bg = 0x000, pixel (x,y) lit per font_bitmap for 'A', RGB at cycle +2, hsync/vsync delayed 2.
- **Line wrap:** write 80 × 0x41 → cursor (0,1); then CR, LF → cursor (0,2); BS at col 0 → unchanged.
- **Scroll:** fill rows to row 59, send LF → top = 1, wr_ready low 80 cycles, logical row 59 all 0x20, former row 1 now displays at y = 0..7.
- **Form feed:** send 0x0C mid-screen → busy for 4800 cycles, cursor (0,0), top = 0; reset_n pulsed mid-clear → clear restarts from 0.
- **Cursor blink:** BLINK_FRAMES = 2, cursor_en = 1 → underline at font_row 7 of the cursor cell appears in frames 0–1, absent in frames 2–3; cursor_en = 0 → never drawn.

Source files
------------

// File: rtl/vga_text_console.sv
// vga_text_console: byte-stream character terminal with a scrolling
// buffer, blinking underline cursor and a 2-cycle pixel pipeline.
module vga_text_console #(
  parameter int COLS = 80,
  parameter int ROWS = 60,
  parameter int CELL = 8,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [7:0]                wr_data,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  output logic                      busy,
  input  logic [11:0]               fg_color,
  input  logic [11:0]               bg_color,
  input  logic                      cursor_en,
  input  logic                      video_on_in,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic [9:0]                x_in,
  input  logic [9:0]                y_in,
  output logic [7:0]                font_code,
  output logic [$clog2(CELL)-1:0]   font_row,
  input  logic [CELL-1:0]           font_bitmap,
  output logic                      hsync,
  output logic                      vsync,
  output logic [3:0]                red,
  output logic [3:0]                green,
  output logic [3:0]                blue,
  output logic [$clog2(COLS)-1:0]   cursor_col,
  output logic [$clog2(ROWS)-1:0]   cursor_row
);

  localparam int CW = $clog2(CELL);
  localparam int CB = $clog2(COLS);
  localparam int RB = $clog2(ROWS);
  localparam int N  = COLS * ROWS;
  localparam int AW = $clog2(N);
  localparam int GW = 10 - CW;
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [CB-1:0] COL_MAX  = CB'(COLS - 1);
  localparam logic [RB-1:0] ROW_MAX  = RB'(ROWS - 1);
  localparam logic [AW-1:0] LINE_MAX = AW'(COLS - 1);
  localparam logic [AW-1:0] CELL_MAX = AW'(N - 1);
  localparam logic [GW-1:0] G_COLS   = GW'(COLS);
  localparam logic [GW-1:0] G_ROWS   = GW'(ROWS);
  localparam logic [RB:0]   ROWS_W   = (RB + 1)'(ROWS);
  localparam logic [FW-1:0] F_MAX    = FW'(BLINK_FRAMES - 1);
  localparam logic [CW-1:0] UL_ROW   = CW'(CELL - 1);

  typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_ALL} state_t;

  state_t        state, state_n;
  logic [CB-1:0] col, col_n;
  logic [RB-1:0] row, row_n;
  logic [RB-1:0] top, top_n;
  logic [AW-1:0] cnt, cnt_n;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic          we;
  logic          accept;
  logic          adv;
  logic [7:0]    cells [N];

  // Logical row r maps to physical row (r + t) mod ROWS.
  function automatic logic [AW-1:0] addr_of(
    input logic [RB-1:0] r,
    input logic [CB-1:0] c,
    input logic [RB-1:0] t
  );
    logic [RB:0] s;
    s = {1'b0, r} + {1'b0, t};
    if (s >= ROWS_W) s = s - ROWS_W;
    return AW'(int'(s) * COLS + int'(c));
  endfunction

  assign wr_ready   = (state == IDLE);
  assign busy       = (state == CLR_LINE) || (state == CLR_ALL);
  assign accept     = wr_valid & wr_ready;
  assign cursor_col = col;
  assign cursor_row = row;

  always_comb begin
    state_n = state;
    col_n   = col;
    row_n   = row;
    top_n   = top;
    cnt_n   = cnt;
    we      = 1'b0;
    waddr   = '0;
    wdata   = 8'h20;
    adv     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            (wr_data >= 8'h20) && (wr_data <= 8'h7e): begin
              we    = 1'b1;
              waddr = addr_of(row, col, top);
              wdata = wr_data;
              if (col == COL_MAX) begin
                col_n = '0;
                adv   = 1'b1;
              end else begin
                col_n = col + 1'b1;
              end
            end
            wr_data == 8'h0a: begin
              col_n = '0;
              adv   = 1'b1;
            end
            wr_data == 8'h0d: col_n = '0;
            wr_data == 8'h08: begin
              if (col != '0) begin
                col_n = col - 1'b1;
                we    = 1'b1;
                waddr = addr_of(row, col - 1'b1, top);
              end
            end
            wr_data == 8'h0c: begin
              state_n = CLR_ALL;
              cnt_n   = '0;
            end
            default: ;
          endcase
          if (adv) begin
            if (row != ROW_MAX) begin
              row_n = row + 1'b1;
            end else begin
              top_n   = (top == ROW_MAX) ? '0 : top + 1'b1;
              state_n = CLR_LINE;
              cnt_n   = '0;
            end
          end
        end
      end
      CLR_LINE: begin
        we    = 1'b1;
        waddr = addr_of(ROW_MAX, cnt[CB-1:0], top);
        cnt_n = cnt + 1'b1;
        if (cnt == LINE_MAX) state_n = IDLE;
      end
      CLR_ALL: begin
        we    = 1'b1;
        waddr = cnt;
        cnt_n = cnt + 1'b1;
        if (cnt == CELL_MAX) begin
          state_n = IDLE;
          cnt_n   = '0;
          top_n   = '0;
          col_n   = '0;
          row_n   = '0;
        end
      end
      default: state_n = CLR_ALL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLR_ALL;
      col   <= '0;
      row   <= '0;
      top   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      col   <= col_n;
      row   <= row_n;
      top   <= top_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (we) cells[waddr] <= wdata;
  end

  logic [FW-1:0] fcnt;
  logic          vs_d;
  logic          blink;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_d  <= 1'b1;
      fcnt  <= '0;
      blink <= 1'b1;
    end else begin
      vs_d <= vsync_in;
      if (vs_d && !vsync_in) begin
        if (fcnt == F_MAX) begin
          fcnt  <= '0;
          blink <= ~blink;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

  logic [GW-1:0] cx, cy;
  logic          in_grid;
  logic          hit;
  logic [AW-1:0] raddr;

  assign cx      = x_in[9:CW];
  assign cy      = y_in[9:CW];
  assign in_grid = (cx < G_COLS) && (cy < G_ROWS);
  assign raddr   = in_grid ? addr_of(cy[RB-1:0], cx[CB-1:0], top) : '0;
  assign hit     = in_grid && (cx[CB-1:0] == col) && (cy[RB-1:0] == row);

  logic [7:0]    char_s1;
  logic [CW-1:0] colbit_s1;
  logic          video_s1, grid_s1, hit_s1, hs_s1, vs_s1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      char_s1   <= '0;
      font_row  <= '0;
      colbit_s1 <= '0;
      video_s1  <= 1'b0;
      grid_s1   <= 1'b0;
      hit_s1    <= 1'b0;
      hs_s1     <= 1'b1;
      vs_s1     <= 1'b1;
    end else begin
      char_s1   <= cells[raddr];
      font_row  <= y_in[CW-1:0];
      colbit_s1 <= x_in[CW-1:0];
      video_s1  <= video_on_in;
      grid_s1   <= in_grid;
      hit_s1    <= hit;
      hs_s1     <= hsync_in;
      vs_s1     <= vsync_in;
    end
  end

  assign font_code = char_s1;

  logic [CW-1:0] bit_idx;
  logic          ul;
  logic          pix;
  logic [11:0]   rgb;

  assign bit_idx = ~colbit_s1;
  assign ul      = cursor_en & blink & hit_s1 & (font_row == UL_ROW);
  assign pix     = grid_s1 & (font_bitmap[bit_idx] | ul);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb   <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      rgb   <= video_s1 ? (pix ? fg_color : bg_color) : 12'h000;
      hsync <= hs_s1;
      vsync <= vs_s1;
    end
  end

  assign red   = rgb[11:8];
  assign green = rgb[7:4];
  assign blue  = rgb[3:0];

endmodule

// File: tb/tb_vga_text_console.sv
// Bench for vga_text_console: logical-screen model with a per-cycle
// pixel compare, plus literal probes of key pixels and timings.
module tb_vga_text_console;

  localparam int COLS = 80;
  localparam int ROWS = 60;
  localparam int CELL = 8;
  localparam int BF   = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        busy;
  logic [11:0] fg_color, bg_color;
  logic        cursor_en;
  logic        video_on_in, hsync_in, vsync_in;
  logic [9:0]  x_in, y_in;
  logic [7:0]  font_code;
  logic [2:0]  font_row;
  logic [7:0]  font_bitmap;
  logic        hsync, vsync;
  logic [3:0]  red, green, blue;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;

  vga_text_console #(
    .COLS(COLS), .ROWS(ROWS), .CELL(CELL), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .busy(busy), .fg_color(fg_color), .bg_color(bg_color),
    .cursor_en(cursor_en), .video_on_in(video_on_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .x_in(x_in), .y_in(y_in), .font_code(font_code),
    .font_row(font_row), .font_bitmap(font_bitmap),
    .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .cursor_col(cursor_col), .cursor_row(cursor_row)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] font(input logic [7:0] c, input logic [2:0] r);
    if (c == 8'h20) return 8'h00;
    return c ^ {r, r, r[1:0]};
  endfunction

  always_comb font_bitmap = font(font_code, font_row);

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: screen kept in logical coordinates; scrolling moves rows.
  logic [7:0] scr [ROWS][COLS];
  int ccol, crow;

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = 8'h20;
    ccol = 0;
    crow = 0;
  endtask

  task automatic model_lf();
    if (crow < ROWS - 1) begin
      crow++;
    end else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = scr[r + 1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS - 1][c] = 8'h20;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7e) begin
      scr[crow][ccol] = b;
      if (ccol == COLS - 1) begin
        ccol = 0;
        model_lf();
      end else ccol++;
    end else if (b == 8'h0a) begin
      ccol = 0;
      model_lf();
    end else if (b == 8'h0d) begin
      ccol = 0;
    end else if (b == 8'h08) begin
      if (ccol > 0) begin
        ccol--;
        scr[crow][ccol] = 8'h20;
      end
    end else if (b == 8'h0c) begin
      model_clear();
    end
  endtask

  // Per-cycle compare against the model.
  logic        chk_en = 1'b0;
  logic        v1 = 1'b0, v2 = 1'b0;
  logic        s_vid, s_grid, s_bit, s_ul, s_hs, s_vs;
  logic [7:0]  s_code, fb;
  logic [11:0] e_rgb;
  logic        e_hs, e_vs, m_blink, m_pix;
  int          frames = 0;
  logic        pvs = 1'b1;
  int          mcx, mcy, mr, mb;

  always @(negedge clk) begin
    if (!reset_n) begin
      v1 = 1'b0;
      v2 = 1'b0;
      frames = 0;
      pvs = 1'b1;
    end else begin
      if (v2 && chk_en) begin
        check("pixel rgb", {red, green, blue}, e_rgb);
        check("hsync delay", hsync, e_hs);
        check("vsync delay", vsync, e_vs);
      end
      v2 = 1'b0;
      if (v1 && chk_en) begin
        if (s_grid) check("font code", font_code, s_code);
        m_blink = ((frames / BF) % 2) == 0;
        m_pix = s_grid && (s_bit || (cursor_en && m_blink && s_ul));
        e_rgb = !s_vid ? 12'h000 : (m_pix ? fg_color : bg_color);
        e_hs = s_hs;
        e_vs = s_vs;
        v2 = 1'b1;
      end
      if (pvs && !vsync_in) frames++;
      pvs = vsync_in;
      v1 = chk_en;
      mcx = int'(x_in) / CELL;
      mcy = int'(y_in) / CELL;
      mr = int'(y_in) % CELL;
      mb = 7 - int'(x_in) % CELL;
      s_grid = (mcx < COLS) && (mcy < ROWS);
      s_code = s_grid ? scr[mcy][mcx] : 8'h00;
      fb = font(s_code, 3'(mr));
      s_bit = s_grid && fb[mb];
      s_ul = s_grid && mcx == ccol && mcy == crow && mr == CELL - 1;
      s_vid = video_on_in;
      s_hs = hsync_in;
      s_vs = vsync_in;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    wr_data = b;
    wr_valid = 1'b1;
    @(negedge clk);
    while (!wr_ready && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (!wr_ready) check("send timeout", 0, 1);
    step();
    wr_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic b2b(input logic [7:0] a, input logic [7:0] b);
    wr_data = a;
    wr_valid = 1'b1;
    @(negedge clk);
    check("b2b ready first", wr_ready, 1);
    step();
    model_byte(a);
    wr_data = b;
    @(negedge clk);
    check("b2b ready second", wr_ready, 1);
    step();
    wr_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic count_busy(input bit use_busy, output int n);
    n = 0;
    @(negedge clk);
    while ((use_busy ? busy : !wr_ready) && n < 10000) begin
      n++;
      @(negedge clk);
    end
    step();
  endtask

  task automatic probe(input int x, input int y, input logic [11:0] exp, input string name);
    chk_en = 1'b1;
    video_on_in = 1'b1;
    x_in = 10'(x);
    y_in = 10'(y);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check(name, {red, green, blue}, exp);
    step();
    chk_en = 1'b0;
  endtask

  task automatic scan();
    chk_en = 1'b1;
    video_on_in = 1'b1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        x_in = 10'(c * CELL + (c + r) % CELL);
        y_in = 10'(r * CELL + (c * 3 + r) % CELL);
        hsync_in = ((c + r) % 7) != 0;
        step();
      end
    hsync_in = 1'b1;
    x_in = 10'd700; y_in = 10'd10; step();
    x_in = 10'd5; y_in = 10'd490; step();
    video_on_in = 1'b0;
    x_in = 10'd1; y_in = 10'd0; step();
    video_on_in = 1'b1;
    repeat (3) step();
    chk_en = 1'b0;
  endtask

  task automatic pulse_vs();
    chk_en = 1'b1;
    vsync_in = 1'b0;
    repeat (2) step();
    vsync_in = 1'b1;
    repeat (3) step();
    chk_en = 1'b0;
  endtask

  task automatic check_cursor(input string name, input int c, input int r);
    check({name, " col"}, cursor_col, c);
    check({name, " row"}, cursor_row, r);
  endtask

  int n;

  initial begin
    reset_n = 1'b0;
    wr_data = 8'h00;
    wr_valid = 1'b0;
    fg_color = 12'hfff;
    bg_color = 12'h000;
    cursor_en = 1'b0;
    video_on_in = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    x_in = '0;
    y_in = '0;
    model_clear();
    repeat (3) step();
    check("reset rgb", {red, green, blue}, 12'h000);
    check("reset hsync", hsync, 1);
    check("reset vsync", vsync, 1);
    check("reset font_code", font_code, 8'h00);
    check("reset wr_ready", wr_ready, 0);
    check("reset busy", busy, 1);
    reset_n = 1'b1;
    count_busy(1'b0, n);
    check("reset clear length", n, COLS * ROWS);
    check("busy after clear", busy, 0);
    check_cursor("after reset", 0, 0);
    fg_color = 12'hf3c;
    bg_color = 12'h0a5;
    scan();

    fg_color = 12'hfff;
    bg_color = 12'h000;
    send(8'h41);
    check_cursor("after A", 1, 0);
    probe(1, 0, 12'hfff, "A r0 x1");
    probe(0, 0, 12'h000, "A r0 x0");
    probe(7, 0, 12'hfff, "A r0 x7");
    probe(2, 1, 12'hfff, "A r1 x2");
    probe(3, 1, 12'h000, "A r1 x3");
    hsync_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("hsync after 1 cycle", hsync, 1);
    @(posedge clk);
    @(negedge clk);
    check("hsync after 2 cycles", hsync, 0);
    step();
    hsync_in = 1'b1;

    for (int i = 0; i < COLS - 1; i++) send(8'h41);
    check_cursor("line wrap", 0, 1);
    send(8'h42);
    send(8'h0d);
    check_cursor("after CR", 0, 1);
    send(8'h0a);
    check_cursor("after CR LF", 0, 2);
    send(8'h08);
    check_cursor("BS at col 0", 0, 2);
    b2b(8'h51, 8'h52);
    check_cursor("after QR", 2, 2);
    send(8'h08);
    check_cursor("after BS", 1, 2);
    send(8'h01);
    send(8'h7f);
    check_cursor("ignored bytes", 1, 2);
    probe(1, 16, 12'hfff, "Q pixel");
    probe(9, 16, 12'h000, "BS cleared cell");
    cursor_en = 1'b1;
    fg_color = 12'hf3c;
    bg_color = 12'h0a5;
    scan();

    for (int r = 2; r < ROWS - 1; r++) begin
      send(8'(8'h61 + r % 26));
      send(8'h0a);
    end
    check_cursor("last row", 0, ROWS - 1);
    send(8'h7a);
    send(8'h0a);
    count_busy(1'b0, n);
    check("scroll busy length", n, COLS);
    check_cursor("after scroll", 0, ROWS - 1);
    cursor_en = 1'b0;
    fg_color = 12'hfff;
    bg_color = 12'h000;
    probe(1, 0, 12'hfff, "scrolled B x1");
    probe(6, 0, 12'hfff, "scrolled B x6");
    probe(7, 0, 12'h000, "scrolled B x7");
    probe(1, (ROWS - 1) * CELL, 12'h000, "new last row blank");
    cursor_en = 1'b1;
    fg_color = 12'h7e1;
    bg_color = 12'h31c;
    scan();

    send(8'h0c);
    count_busy(1'b1, n);
    check("form feed length", n, COLS * ROWS);
    check_cursor("after FF", 0, 0);
    cursor_en = 1'b0;
    fg_color = 12'hfff;
    bg_color = 12'h000;
    send(8'h43);
    probe(1, 0, 12'hfff, "C after FF x1");
    probe(0, 0, 12'h000, "C after FF x0");
    send(8'h44);
    send(8'h0c);
    repeat (1000) step();
    check("busy mid clear", busy, 1);
    reset_n = 1'b0;
    #1;
    check("async reset rgb", {red, green, blue}, 12'h000);
    check("async reset hsync", hsync, 1);
    check("async reset font_code", font_code, 8'h00);
    check("async reset ready", wr_ready, 0);
    step();
    reset_n = 1'b1;
    model_clear();
    count_busy(1'b1, n);
    check("restart clear length", n, COLS * ROWS);
    check_cursor("after restart", 0, 0);
    cursor_en = 1'b1;
    scan();

    fg_color = 12'hfff;
    bg_color = 12'h000;
    probe(0, 7, 12'hfff, "blink frame 0");
    probe(0, 6, 12'h000, "no underline row 6");
    pulse_vs();
    probe(0, 7, 12'hfff, "blink frame 1");
    pulse_vs();
    probe(0, 7, 12'h000, "blink frame 2");
    pulse_vs();
    probe(0, 7, 12'h000, "blink frame 3");
    pulse_vs();
    probe(0, 7, 12'hfff, "blink frame 4");
    cursor_en = 1'b0;
    probe(0, 7, 12'h000, "cursor disabled");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
